// File: rtl/fb_packet_rx_if.sv
// Word-serial receive stream into the feedback-packet decoder.
// The radio receive buffer is the master; the decoder is the slave.
interface fb_packet_rx_if #(
  parameter int WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/fb_packet_rx.sv
// Feedback-packet decoder: validates header, length, checksum and source,
// then presents the four fields and starts the cost-learning stage.
module fb_packet_rx #(
   parameter int         WORD_WIDTH   = 16,
   parameter logic [7:0] FB_TYPE      = 8'h01,
   parameter int         FB_LEN       = 5,
   parameter int         DONE_TIMEOUT = 1023
) (
   input  logic                  clock,
   input  logic                  rst,
   fb_packet_rx_if.slave         in_if,
   input  logic [WORD_WIDTH-1:0] node_id,
   output logic [WORD_WIDTH-1:0] fsourceID,
   output logic [WORD_WIDTH-1:0] fbatteryStat,
   output logic [WORD_WIDTH-1:0] fValue,
   output logic [WORD_WIDTH-1:0] fclusterID,
   output logic                  lc_en,
   input  logic                  lc_done,
   output logic [15:0]           rx_count,
   output logic [15:0]           drop_count
);

   localparam int              TW         = (DONE_TIMEOUT < 1) ? 1 : $clog2(DONE_TIMEOUT + 1);
   localparam logic [7:0]      LEN_CODE   = 8'(FB_LEN);
   localparam logic [7:0]      LAST_IDX   = 8'(FB_LEN - 1);
   localparam logic [TW-1:0]   TIMEOUT_W  = TW'(DONE_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_COLLECT, S_DISCARD, S_CHECK, S_ISSUE, S_WAIT_DONE
   } state_t;

   state_t                state;
   logic                  ready_q;
   logic [7:0]            cnt;
   logic [WORD_WIDTH-1:0] xor_acc;
   logic [WORD_WIDTH-1:0] shadow [4];
   logic [TW-1:0]         timer;

   logic                  xfer;
   logic [7:0]            hdr_type;
   logic [7:0]            hdr_len;

   assign in_if.in_ready = ready_q;
   assign xfer           = in_if.in_valid & ready_q;
   assign hdr_type       = in_if.in_data[15:8];
   assign hdr_len        = in_if.in_data[7:0];

   always_ff @(posedge clock) begin
      if (rst) begin
         state        <= S_IDLE;
         ready_q      <= 1'b1;
         cnt          <= '0;
         xor_acc      <= '0;
         timer        <= '0;
         lc_en        <= 1'b0;
         fsourceID    <= '0;
         fbatteryStat <= '0;
         fValue       <= '0;
         fclusterID   <= '0;
         rx_count     <= '0;
         drop_count   <= '0;
         // NOTE: the shadow array is only four words, so clearing it costs nothing
         // and keeps a reset mid-packet from leaving stale fields behind.
         for (int i = 0; i < 4; i++) shadow[i] <= '0;
      end else begin
         // NOTE: every register here uses <= so all branches see pre-edge values.
         lc_en <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (xfer) begin
                  if (hdr_type == FB_TYPE && hdr_len == LEN_CODE) begin
                     state   <= S_COLLECT;
                     cnt     <= '0;
                     xor_acc <= in_if.in_data;
                  end else begin
                     drop_count <= drop_count + 16'd1;
                     if (hdr_len != 8'd0) begin
                        state <= S_DISCARD;
                        cnt   <= hdr_len;
                     end
                  end
               end
            end

            S_COLLECT: begin
               if (xfer) begin
                  xor_acc <= xor_acc ^ in_if.in_data;
                  if (cnt < 8'd4) shadow[cnt[1:0]] <= in_if.in_data;
                  if (cnt == LAST_IDX) begin
                     state   <= S_CHECK;
                     ready_q <= 1'b0;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
            end

            S_DISCARD: begin
               if (xfer) begin
                  cnt <= cnt - 8'd1;
                  if (cnt == 8'd1) state <= S_IDLE;
               end
            end

            // Running XOR includes the checksum word, so a clean packet folds to zero.
            S_CHECK: begin
               if (xor_acc == '0 && shadow[0] != node_id) begin
                  fsourceID    <= shadow[0];
                  fbatteryStat <= shadow[1];
                  fValue       <= shadow[2];
                  fclusterID   <= shadow[3];
                  rx_count     <= rx_count + 16'd1;
                  lc_en        <= 1'b1;
                  state        <= S_ISSUE;
               end else begin
                  drop_count <= drop_count + 16'd1;
                  state      <= S_IDLE;
                  ready_q    <= 1'b1;
               end
            end

            S_ISSUE: begin
               state <= S_WAIT_DONE;
               timer <= '0;
            end

            S_WAIT_DONE: begin
               if (lc_done) begin
                  state   <= S_IDLE;
                  ready_q <= 1'b1;
               end else if (timer == TIMEOUT_W) begin
                  drop_count <= drop_count + 16'd1;
                  state      <= S_IDLE;
                  ready_q    <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            default: begin
               state   <= S_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule
